// File: rtl/cdb_pkg.sv
// ---------------------------------------------------------------------------
// cdb_pkg
// Shared types for the common data bus (CDB) result path.
//   CDB_TAG_W   : processor-wide ROB/RS tag width
//   CDB_DATA_W  : result value width
//   cdb_entry_t : one buffered/broadcast result {tag, data, exc}
// ---------------------------------------------------------------------------
package cdb_pkg;

    localparam int CDB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic                  exc;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// ---------------------------------------------------------------------------
// cdb_fifo
// Per-FU result FIFO feeding the CDB arbiter.
// Ports:
//   clk_i      : clock
//   rst_ni     : async reset, active low (FIFO empty)
//   flush_i    : drop all entries; push/pop at the same edge are ignored
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : remove head (ignored when empty)
//   wdata_i    : entry to write
//   head_o     : current head entry (valid when count_o != 0)
//   count_o    : registered occupancy
//   ready_o    : count_o < DEPTH (a same-edge pop does not make a full FIFO ready)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  cdb_entry_t       wdata_i,
    output cdb_entry_t       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ready_o
);

    cdb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign ready_o = (cnt_q < CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && ready_o && !flush_i;
    assign do_pop  = pop_i && (cnt_q != '0) && !flush_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Collects results from NUM_FU functional units into per-FU FIFOs and
// broadcasts at most one per cycle on the registered CDB outputs.
// Ports:
//   clk_in, rst_in (async, active low), flush_in (drop all buffered results)
//   fu_valid_in/fu_tag_in/fu_data_in/fu_exc_in : per-FU result, FU i at slice i
//   fu_ready_out                               : FU i FIFO can accept
//   cdb_valid_out/tag/data/exc/src             : registered broadcast
// Build option:
//   CDB_ROUND_ROBIN_EN defined   -> rotating priority starting at rr pointer
//   CDB_ROUND_ROBIN_EN undefined -> fixed priority, lowest FU index wins
// TAG_W/DATA_W must match CDB_TAG_W/CDB_DATA_W of cdb_pkg.
// ---------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_FU     = 4,
    parameter  int TAG_W      = CDB_TAG_W,
    parameter  int DATA_W     = CDB_DATA_W,
    parameter  int FIFO_DEPTH = 2,
    localparam int SRC_W      = $clog2(NUM_FU),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic [NUM_FU-1:0]        fu_valid_in,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag_in,
    input  logic [NUM_FU*DATA_W-1:0] fu_data_in,
    input  logic [NUM_FU-1:0]        fu_exc_in,
    output logic [NUM_FU-1:0]        fu_ready_out,
    output logic                     cdb_valid_out,
    output logic [TAG_W-1:0]         cdb_tag_out,
    output logic [DATA_W-1:0]        cdb_data_out,
    output logic                     cdb_exc_out,
    output logic [SRC_W-1:0]         cdb_src_out
);

    cdb_entry_t       heads [NUM_FU];
    logic [CNT_W-1:0] fifo_cnt [NUM_FU];
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] grant;
    logic [SRC_W-1:0]  win_idx;
    logic              grant_any;
    cdb_entry_t        win_entry;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic              cdb_exc_q;
    logic [SRC_W-1:0]  cdb_src_q;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        cdb_entry_t wr_entry;

        assign wr_entry.tag  = CDB_TAG_W'(fu_tag_in[g*TAG_W +: TAG_W]);
        assign wr_entry.data = CDB_DATA_W'(fu_data_in[g*DATA_W +: DATA_W]);
        assign wr_entry.exc  = fu_exc_in[g];
        assign nonempty[g]   = (fifo_cnt[g] != '0);

        cdb_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_in),
            .rst_ni  (rst_in),
            .flush_i (flush_in),
            .push_i  (fu_valid_in[g]),
            .pop_i   (grant[g]),
            .wdata_i (wr_entry),
            .head_o  (heads[g]),
            .count_o (fifo_cnt[g]),
            .ready_o (fu_ready_out[g])
        );
    end

`ifdef CDB_ROUND_ROBIN_EN
    logic [SRC_W-1:0] rr_q;
    logic [SRC_W-1:0] rr_d;

    // Search starts at rr_q and wraps; first non-empty FIFO wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!grant_any && nonempty[SRC_W'(idx)]) begin
                grant_any = 1'b1;
                win_idx   = SRC_W'(idx);
            end
        end
    end

    assign rr_d = (win_idx == SRC_W'(NUM_FU - 1)) ? '0 : win_idx + SRC_W'(1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_q <= '0;
        end else if (!flush_in && grant_any) begin
            rr_q <= rr_d;
        end
    end
`else
    // Scan from the top down so the lowest non-empty index is left in win_idx.
    always_comb begin
        grant_any = 1'b0;
        win_idx   = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (nonempty[SRC_W'(k)]) begin
                grant_any = 1'b1;
                win_idx   = SRC_W'(k);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (grant_any) grant[win_idx] = 1'b1;
    end

    assign win_entry = heads[win_idx];

    // Payload holds its last value when nothing is broadcast.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_exc_q   <= 1'b0;
            cdb_src_q   <= '0;
        end else if (flush_in) begin
            cdb_valid_q <= 1'b0;
        end else begin
            cdb_valid_q <= grant_any;
            if (grant_any) begin
                cdb_tag_q  <= TAG_W'(win_entry.tag);
                cdb_data_q <= DATA_W'(win_entry.data);
                cdb_exc_q  <= win_entry.exc;
                cdb_src_q  <= win_idx;
            end
        end
    end

    assign cdb_valid_out = cdb_valid_q;
    assign cdb_tag_out   = cdb_tag_q;
    assign cdb_data_out  = cdb_data_q;
    assign cdb_exc_out   = cdb_exc_q;
    assign cdb_src_out   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed vectors with hand-computed expectations plus a scoreboarded
// random phase for cdb_arbiter (NUM_FU=4, TAG_W=5, DATA_W=32, depth 2).
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic         flush_in = 1'b0;
    logic [3:0]   fu_valid_in = '0;
    logic [19:0]  fu_tag_in = '0;
    logic [127:0] fu_data_in = '0;
    logic [3:0]   fu_exc_in = '0;
    logic [3:0]   fu_ready_out;
    logic         cdb_valid_out;
    logic [4:0]   cdb_tag_out;
    logic [31:0]  cdb_data_out;
    logic         cdb_exc_out;
    logic [1:0]   cdb_src_out;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter #(
        .NUM_FU     (4),
        .TAG_W      (5),
        .DATA_W     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush_in      (flush_in),
        .fu_valid_in   (fu_valid_in),
        .fu_tag_in     (fu_tag_in),
        .fu_data_in    (fu_data_in),
        .fu_exc_in     (fu_exc_in),
        .fu_ready_out  (fu_ready_out),
        .cdb_valid_out (cdb_valid_out),
        .cdb_tag_out   (cdb_tag_out),
        .cdb_data_out  (cdb_data_out),
        .cdb_exc_out   (cdb_exc_out),
        .cdb_src_out   (cdb_src_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [4:0] t,
                         input logic [31:0] d, input logic e);
        fu_valid_in[i]       = v;
        fu_tag_in[i*5 +: 5]  = t;
        fu_data_in[i*32 +: 32] = d;
        fu_exc_in[i]         = e;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        clear_all();
        rst_in = 1'b0;
        #3;
        rst_in = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        a1;
        int          n1;
        int          k1;
        int          seen;
        int          uid;
        int          left;
        logic [3:0]  acc;
        logic [31:0] expd;
        logic [31:0] sb [4][$];
        int          s;
        int          first_src;

        // Reset values
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_valid", cdb_valid_out, 0);
        chk("rst_ready", fu_ready_out, 4'hF);
        chk("rst_tag",   cdb_tag_out, 0);
        chk("rst_data",  cdb_data_out, 0);
        chk("rst_src",   cdb_src_out, 0);
        chk("rst_exc",   cdb_exc_out, 0);
        rst_in = 1'b1;
        step();

        // Single result, FU2
        drive(2, 1'b1, 5'd5, 32'h0000_0001, 1'b0);
        step();
        drive(2, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("single_lat0", cdb_valid_out, 0);
        step();
        chk("single_valid", cdb_valid_out, 1);
        chk("single_tag",   cdb_tag_out, 5);
        chk("single_data",  cdb_data_out, 1);
        chk("single_src",   cdb_src_out, 2);
        chk("single_exc",   cdb_exc_out, 0);
        step();
        chk("single_once",  cdb_valid_out, 0);
        chk("single_hold",  cdb_tag_out, 5);

        // Contention: all four push at once
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i), (i == 3));
        step();
        clear_all();
        for (int b = 0; b < 4; b++) begin
            step();
            chk("burst_valid", cdb_valid_out, 1);
            chk("burst_src",   cdb_src_out, 64'(b));
            chk("burst_tag",   cdb_tag_out, 64'(b + 1));
            chk("burst_exc",   cdb_exc_out, 64'(b == 3));
        end
        step();
        chk("burst_end", cdb_valid_out, 0);

        // FU0 alone, then FU0 and FU2 together
        drive(0, 1'b1, 5'd7, 32'h7, 1'b0);
        step();
        clear_all();
        step();
        chk("pair_pre_src", cdb_src_out, 0);
        drive(0, 1'b1, 5'd8, 32'h8, 1'b0);
        drive(2, 1'b1, 5'd9, 32'h9, 1'b0);
        step();
        clear_all();
`ifdef CDB_ROUND_ROBIN_EN
        first_src = 2;
`else
        first_src = 0;
`endif
        step();
        chk("pair_first_src",  cdb_src_out, 64'(first_src));
        step();
        chk("pair_second_src", cdb_src_out, 64'(2 - first_src));
        chk("pair_second_vld", cdb_valid_out, 1);

`ifndef CDB_ROUND_ROBIN_EN
        // Fixed priority starvation of FU3 by a continuously pushing FU0
        drive(0, 1'b1, 5'd10, 32'h10, 1'b0);
        drive(3, 1'b1, 5'd11, 32'h11, 1'b0);
        step();
        drive(3, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step();
            chk("starve_src", cdb_src_out, 0);
        end
        drive(0, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        chk("starve_last_fu0", cdb_src_out, 0);
        step();
        chk("starve_fu3_src", cdb_src_out, 3);
        chk("starve_fu3_tag", cdb_tag_out, 11);
`endif

        // Backpressure on FU1 while FU0 keeps winning
        do_reset();
        n1 = 0;
        k1 = 0;
        drive(0, 1'b1, 5'd20, 32'h20, 1'b0);
        drive(1, 1'b1, 5'd11, 32'h11, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (c == 6) drive(0, 1'b0, 5'd0, 32'd0, 1'b0);
            a1 = fu_valid_in[1] && fu_ready_out[1];
            step();
            if (a1) begin
                n1++;
                if (n1 < 3) drive(1, 1'b1, 5'(11 + n1), 32'h11 + 32'(n1), 1'b0);
                else        drive(1, 1'b0, 5'd0, 32'd0, 1'b0);
            end
            if (c == 1) chk("bp_full", fu_ready_out[1], 0);
`ifndef CDB_ROUND_ROBIN_EN
            if (c == 4) begin
                chk("bp_held",     fu_ready_out[1], 0);
                chk("bp_fu0_wins", cdb_src_out, 0);
            end
`endif
            if (cdb_valid_out && cdb_src_out == 2'd1) begin
                chk("bp_order", cdb_tag_out, 64'(11 + k1));
                k1++;
            end
        end
        chk("bp_accepts", n1, 3);
        chk("bp_bcasts",  k1, 3);

        // Flush with three non-empty FIFOs
        do_reset();
        drive(0, 1'b1, 5'd1, 32'h1, 1'b0);
        drive(1, 1'b1, 5'd2, 32'h2, 1'b0);
        drive(2, 1'b1, 5'd3, 32'h3, 1'b0);
        step();
        clear_all();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("flush_valid", cdb_valid_out, 0);
        chk("flush_ready", fu_ready_out, 4'hF);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (cdb_valid_out) seen++;
        end
        chk("flush_quiet", seen, 0);

        // Asynchronous reset mid-traffic
        for (int i = 0; i < 4; i++) drive(i, 1'b1, 5'(i + 1), 32'(i), 1'b0);
        step();
        clear_all();
        step();
        chk("arst_pre_valid", cdb_valid_out, 1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_valid", cdb_valid_out, 0);
        chk("arst_ready", fu_ready_out, 4'hF);
        chk("arst_src",   cdb_src_out, 0);
        #1;
        rst_in = 1'b1;
        step();

        // Random traffic against a per-FU scoreboard
        uid = 1;
        for (int c = 0; c < 300; c++) begin
            acc = fu_valid_in & fu_ready_out;
            for (int i = 0; i < 4; i++)
                if (acc[i]) sb[i].push_back(fu_data_in[i*32 +: 32]);
            step();
            if (cdb_valid_out) begin
                s = int'(cdb_src_out);
                if (sb[s].size() == 0) begin
                    chk("rand_spurious", 1, 0);
                end else begin
                    expd = sb[s].pop_front();
                    chk("rand_data", cdb_data_out, expd);
                    chk("rand_tag",  cdb_tag_out, expd[4:0]);
                    chk("rand_exc",  cdb_exc_out, expd[0]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i] || !fu_valid_in[i]) begin
                    if (c < 250 && ($urandom % 3) != 0) begin
                        drive(i, 1'b1, 5'(uid), 32'(uid), uid[0]);
                        uid++;
                    end else begin
                        drive(i, 1'b0, 5'd0, 32'd0, 1'b0);
                    end
                end
            end
        end
        left = 0;
        for (int i = 0; i < 4; i++) left += sb[i].size();
        chk("rand_drained", left, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
